// File: rtl/lzw_decoder_if.sv
// -----------------------------------------------------------------------------
// lzw_decoder_if
// Handshake bundle between an LZW code producer, the decoder and the character
// consumer.
//   code_in    : code presented to the decoder (CODE_W bits)
//   code_valid : code_in is valid
//   code_ready : decoder accepts a code this cycle
//   char_out   : decoded character (top of the decoder's LIFO)
//   char_valid : char_out is valid
//   char_ready : consumer accepts char_out
// Modports: master = producer/consumer side, slave = decoder side.
// -----------------------------------------------------------------------------
interface lzw_decoder_if #(
   parameter int CODE_W = 12
) ();
   logic [CODE_W-1:0] code_in;
   logic              code_valid;
   logic              code_ready;
   logic [7:0]        char_out;
   logic              char_valid;
   logic              char_ready;

   modport master (
      output code_in, code_valid, char_ready,
      input  code_ready, char_out, char_valid
   );

   modport slave (
      input  code_in, code_valid, char_ready,
      output code_ready, char_out, char_valid
   );
endinterface

// File: rtl/lzw_decoder.sv
// -----------------------------------------------------------------------------
// lzw_decoder
// LZW decompressor: consumes CODE_W-bit codes and rebuilds the 8-bit character
// stream. A dictionary of (prefix code, suffix char) pairs is rebuilt as codes
// arrive; each string is walked from its last char to its root and pushed on a
// LIFO, which is then popped so the characters leave in forward order.
// Ports:
//   clk_i       : clock, all state changes on the rising edge
//   rst_i       : synchronous active-high reset
//   bus         : code input / char output handshakes (slave modport)
//   next_code_o : next dictionary index to be assigned
//   dict_full_o : last dictionary entry has been written
//   busy_o      : decoder is walking, emitting or in error
//   error_o     : sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module lzw_decoder #(
   parameter int CODE_W      = 12,
   parameter int STACK_DEPTH = (1 << CODE_W) - 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   lzw_decoder_if.slave      bus,
   output logic [CODE_W-1:0] next_code_o,
   output logic              dict_full_o,
   output logic              busy_o,
   output logic              error_o
);

   localparam int DICT_SIZE = 1 << CODE_W;
   localparam int SP_W      = $clog2(STACK_DEPTH + 1);

   localparam logic [CODE_W-1:0] FIRST_CODE = CODE_W'(256);
   localparam logic [CODE_W-1:0] LAST_CODE  = {CODE_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_WALK = 3'd2,
      S_EMIT = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [CODE_W-1:0] cur_q, cur_d;          // code being walked
   logic [CODE_W-1:0] prev_q, prev_d;        // previously decoded code
   logic [CODE_W-1:0] code_q, code_d;        // code accepted for the current walk
   logic [7:0]        first_q, first_d;      // first char of the last string
   logic [CODE_W-1:0] next_code_q, next_code_d;
   logic              dict_full_q, dict_full_d;

   logic              push_s;
   logic [7:0]        push_char_s;
   logic              pop_s;
   logic              dict_we_s;
   logic [7:0]        top_char_s;

   // Entries below 256 are never written; literal codes are handled directly.
   logic [7:0]        stack_mem  [0:STACK_DEPTH-1];
   logic [CODE_W-1:0] prefix_mem [0:DICT_SIZE-1];
   logic [7:0]        suffix_mem [0:DICT_SIZE-1];

   // Top-of-LIFO read
   always_comb begin
      top_char_s = stack_mem[sp_q - SP_W'(1)];
   end

   // Next-state, LIFO and dictionary control
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      prev_d      = prev_q;
      code_d      = code_q;
      first_d     = first_q;
      next_code_d = next_code_q;
      dict_full_d = dict_full_q;
      push_s      = 1'b0;
      push_char_s = 8'h00;
      pop_s       = 1'b0;
      dict_we_s   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // No previous code: only a literal can start a stream.
            if (bus.code_valid) begin
               if (bus.code_in < FIRST_CODE) begin
                  push_s      = 1'b1;
                  push_char_s = bus.code_in[7:0];
                  first_d     = bus.code_in[7:0];
                  prev_d      = bus.code_in;
                  state_d     = S_EMIT;
               end else begin
                  state_d = S_ERR;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_WAIT: begin
            if (bus.code_valid) begin
               code_d = bus.code_in;
               if (bus.code_in > next_code_q) begin
                  state_d = S_ERR;
               end else if ((bus.code_in == next_code_q) && !dict_full_q) begin
                  // Code not yet in the dictionary: it is the previous string
                  // plus its own first char, which ends up last in the output.
                  push_s      = 1'b1;
                  push_char_s = first_q;
                  cur_d       = prev_q;
                  state_d     = S_WALK;
               end else begin
                  cur_d   = bus.code_in;
                  state_d = S_WALK;
               end
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WALK: begin
            push_s = 1'b1;
            if (cur_q >= FIRST_CODE) begin
               push_char_s = suffix_mem[cur_q];
               cur_d       = prefix_mem[cur_q];
            end else begin
               // Root reached: this char is the first char of the new string.
               push_char_s = cur_q[7:0];
               first_d     = cur_q[7:0];
               prev_d      = code_q;
               state_d     = S_EMIT;
               if (!dict_full_q) begin
                  dict_we_s = 1'b1;
                  if (next_code_q == LAST_CODE) begin
                     dict_full_d = 1'b1;
                  end else begin
                     next_code_d = next_code_q + CODE_W'(1);
                  end
               end else begin
                  dict_we_s = 1'b0;
               end
            end
         end

         S_EMIT: begin
            if (sp_q == SP_W'(0)) begin
               state_d = S_WAIT;
            end else if (bus.char_ready) begin
               pop_s = 1'b1;
               if (sp_q == SP_W'(1)) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_EMIT;
               end
            end else begin
               state_d = S_EMIT;
            end
         end

         S_ERR: begin
            state_d = S_ERR;
         end

         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   // LIFO pointer update
   always_comb begin
      if (push_s) begin
         sp_d = sp_q + SP_W'(1);
      end else if (pop_s) begin
         sp_d = sp_q - SP_W'(1);
      end else begin
         sp_d = sp_q;
      end
   end

   // State and control registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         sp_q        <= SP_W'(0);
         cur_q       <= CODE_W'(0);
         prev_q      <= CODE_W'(0);
         code_q      <= CODE_W'(0);
         first_q     <= 8'h00;
         next_code_q <= FIRST_CODE;
         dict_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         cur_q       <= cur_d;
         prev_q      <= prev_d;
         code_q      <= code_d;
         first_q     <= first_d;
         next_code_q <= next_code_d;
         dict_full_q <= dict_full_d;
      end
   end

   // LIFO storage write
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         stack_mem[sp_q] <= push_char_s;
      end
   end

   // Dictionary write; not cleared by reset since next_code_q marks valid entries
   always_ff @(posedge clk_i) begin
      if (dict_we_s) begin
         prefix_mem[next_code_q] <= prev_q;
         suffix_mem[next_code_q] <= cur_q[7:0];
      end
   end

   // Output decode from registered state
   always_comb begin
      bus.code_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
      bus.char_valid = (state_q == S_EMIT) && (sp_q != SP_W'(0));
      if (bus.char_valid) begin
         bus.char_out = top_char_s;
      end else begin
         bus.char_out = 8'h00;
      end
      next_code_o = next_code_q;
      dict_full_o = dict_full_q;
      busy_o      = (state_q != S_IDLE) && (state_q != S_WAIT);
      error_o     = (state_q == S_ERR);
   end

endmodule

// File: tb/tb_lzw_decoder.sv
module tb_lzw_decoder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lzw_decoder_if #(.CODE_W(12)) bus12 ();
   lzw_decoder_if #(.CODE_W(9))  bus9 ();

   logic [11:0] nc12;
   logic        full12, busy12, err12;
   logic [8:0]  nc9;
   logic        full9, busy9, err9;

   lzw_decoder #(.CODE_W(12)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus12),
      .next_code_o (nc12),
      .dict_full_o (full12),
      .busy_o      (busy12),
      .error_o     (err12)
   );

   lzw_decoder #(.CODE_W(9)) dut9 (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus9),
      .next_code_o (nc9),
      .dict_full_o (full9),
      .busy_o      (busy9),
      .error_o     (err9)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  got_q[$];
   int          first_lat;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus12.code_valid = 1'b0;
      bus9.code_valid  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Sends one code to the 12-bit decoder and collects its output chars.
   task automatic run_code(input logic [11:0] code, input bit toggle);
      int         wcyc;
      bit         stalled;
      bit         done;
      logic [7:0] held;
      got_q.delete();
      first_lat = -1;
      stalled   = 1'b0;
      held      = 8'h00;
      done      = 1'b0;
      wcyc      = 0;
      while (!bus12.code_ready && wcyc < 100) begin
         @(negedge clk);
         wcyc++;
      end
      if (!bus12.code_ready) begin
         checks++; errors++;
         $display("FAIL code_ready_wait code=%0d got %b want 1", code, bus12.code_ready);
      end
      bus12.code_in    = code;
      bus12.code_valid = 1'b1;
      @(negedge clk);
      bus12.code_valid = 1'b0;
      for (int cyc = 0; cyc < 10000 && !done; cyc++) begin
         if (err12 || bus12.code_ready) begin
            done = 1'b1;
         end else begin
            if (toggle) bus12.char_ready = ~bus12.char_ready;
            if (bus12.char_valid) begin
               if (first_lat < 0) first_lat = cyc + 1;
               if (stalled) begin
                  checks++;
                  if (bus12.char_out !== held) begin
                     errors++;
                     $display("FAIL stall_hold got %h want %h", bus12.char_out, held);
                  end
               end
               if (bus12.char_ready) begin
                  got_q.push_back(bus12.char_out);
                  stalled = 1'b0;
               end else begin
                  held    = bus12.char_out;
                  stalled = 1'b1;
               end
            end
            @(negedge clk);
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL decode_timeout code=%0d got busy want done", code);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus12.code_ready !== 1'b1) begin errors++; $display("FAIL rst_code_ready got %b want 1", bus12.code_ready); end
      checks++; if (bus12.char_valid !== 1'b0) begin errors++; $display("FAIL rst_char_valid got %b want 0", bus12.char_valid); end
      checks++; if (bus12.char_out !== 8'h00) begin errors++; $display("FAIL rst_char_out got %h want 00", bus12.char_out); end
      checks++; if (nc12 !== 12'd256) begin errors++; $display("FAIL rst_next_code got %0d want 256", nc12); end
      checks++; if (full12 !== 1'b0) begin errors++; $display("FAIL rst_dict_full got %b want 0", full12); end
      checks++; if (busy12 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy12); end
      checks++; if (err12 !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", err12); end
      checks++; if (nc9 !== 9'd256) begin errors++; $display("FAIL rst_next_code9 got %0d want 256", nc9); end
   endtask

   // 65 66 256 258 258 -> A | B | AB | ABA (KwKwK) | ABA (entry 258 readback)
   task automatic test_stream(input bit toggle);
      logic [11:0] codes  [5];
      int          lens   [5];
      logic [7:0]  exp_c  [5][3];
      int          exp_nc [5];
      int          exp_lat[5];
      codes   = '{12'd65, 12'd66, 12'd256, 12'd258, 12'd258};
      lens    = '{1, 1, 2, 3, 3};
      exp_c   = '{'{8'h41, 8'h00, 8'h00}, '{8'h42, 8'h00, 8'h00}, '{8'h41, 8'h42, 8'h00},
                  '{8'h41, 8'h42, 8'h41}, '{8'h41, 8'h42, 8'h41}};
      exp_nc  = '{256, 257, 258, 259, 260};
      exp_lat = '{1, 2, 3, -1, -1};
      do_reset();
      bus12.char_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_code(codes[i], toggle);
         checks++;
         if (got_q.size() != lens[i]) begin
            errors++;
            $display("FAIL stream_len t=%0d code=%0d got %0d want %0d", toggle, codes[i], got_q.size(), lens[i]);
         end else begin
            for (int j = 0; j < lens[i]; j++) begin
               checks++;
               if (got_q[j] !== exp_c[i][j]) begin
                  errors++;
                  $display("FAIL stream_char t=%0d code=%0d idx=%0d got %h want %h", toggle, codes[i], j, got_q[j], exp_c[i][j]);
               end
            end
         end
         checks++;
         if (nc12 !== 12'(exp_nc[i])) begin
            errors++;
            $display("FAIL stream_next_code t=%0d code=%0d got %0d want %0d", toggle, codes[i], nc12, exp_nc[i]);
         end
         if (exp_lat[i] > 0) begin
            checks++;
            if (first_lat != exp_lat[i]) begin
               errors++;
               $display("FAIL stream_latency t=%0d code=%0d got %0d want %0d", toggle, codes[i], first_lat, exp_lat[i]);
            end
         end
      end
      checks++; if (err12 !== 1'b0) begin errors++; $display("FAIL stream_error got %b want 0", err12); end
      bus12.char_ready = 1'b1;
   endtask

   task automatic test_bad_first();
      do_reset();
      bus12.char_ready = 1'b1;
      bus12.code_in    = 12'd300;
      bus12.code_valid = 1'b1;
      @(negedge clk);
      bus12.code_valid = 1'b0;
      checks++; if (err12 !== 1'b1) begin errors++; $display("FAIL bad_first_error got %b want 1", err12); end
      checks++; if (bus12.code_ready !== 1'b0) begin errors++; $display("FAIL bad_first_ready got %b want 0", bus12.code_ready); end
      checks++; if (busy12 !== 1'b1) begin errors++; $display("FAIL bad_first_busy got %b want 1", busy12); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus12.char_valid !== 1'b0 || err12 !== 1'b1) begin
            errors++;
            $display("FAIL bad_first_hold cyc=%0d got valid=%b err=%b want valid=0 err=1", k, bus12.char_valid, err12);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_bad_code();
      do_reset();
      bus12.char_ready = 1'b1;
      run_code(12'd65, 1'b0);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h41) begin
         errors++;
         $display("FAIL bad_code_first got size=%0d want 1 char 41", got_q.size());
      end
      run_code(12'd257, 1'b0);
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bad_code_out got %0d chars want 0", got_q.size()); end
      checks++; if (err12 !== 1'b1) begin errors++; $display("FAIL bad_code_error got %b want 1", err12); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus12.char_valid !== 1'b0 || bus12.code_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_code_hold cyc=%0d got valid=%b ready=%b want 0 0", k, bus12.char_valid, bus12.code_ready);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_emit();
      int wcyc;
      do_reset();
      bus12.char_ready = 1'b1;
      run_code(12'd65, 1'b0);
      run_code(12'd66, 1'b0);
      run_code(12'd256, 1'b0);
      bus12.char_ready = 1'b0;
      bus12.code_in    = 12'd258;
      bus12.code_valid = 1'b1;
      @(negedge clk);
      bus12.code_valid = 1'b0;
      wcyc = 0;
      while (!bus12.char_valid && wcyc < 20) begin
         @(negedge clk);
         wcyc++;
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus12.char_valid !== 1'b1 || bus12.char_out !== 8'h41) begin
         errors++;
         $display("FAIL mid_emit_pre got valid=%b char=%h want 1 41", bus12.char_valid, bus12.char_out);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus12.char_valid !== 1'b0) begin errors++; $display("FAIL mid_emit_valid got %b want 0", bus12.char_valid); end
      checks++; if (nc12 !== 12'd256) begin errors++; $display("FAIL mid_emit_next_code got %0d want 256", nc12); end
      checks++; if (bus12.code_ready !== 1'b1) begin errors++; $display("FAIL mid_emit_ready got %b want 1", bus12.code_ready); end
      bus12.char_ready = 1'b1;
      run_code(12'd66, 1'b0);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h42) begin
         errors++;
         $display("FAIL mid_emit_fresh got size=%0d want 1 char 42", got_q.size());
      end
   endtask

   task automatic test_dict_full();
      int wcyc;
      do_reset();
      bus9.char_ready = 1'b1;
      for (int k = 1; k <= 258; k++) begin
         wcyc = 0;
         while (!bus9.code_ready && wcyc < 50) begin
            @(negedge clk);
            wcyc++;
         end
         bus9.code_in    = 9'd65;
         bus9.code_valid = 1'b1;
         @(negedge clk);
         bus9.code_valid = 1'b0;
         wcyc = 0;
         while (!bus9.char_valid && wcyc < 20) begin
            @(negedge clk);
            wcyc++;
         end
         checks++;
         if (bus9.char_valid !== 1'b1 || bus9.char_out !== 8'h41) begin
            errors++;
            $display("FAIL full_char k=%0d got valid=%b char=%h want 1 41", k, bus9.char_valid, bus9.char_out);
         end
         if (k == 2) begin
            checks++; if (nc9 !== 9'd257) begin errors++; $display("FAIL full_nc_k2 got %0d want 257", nc9); end
         end
         if (k == 256) begin
            checks++;
            if (nc9 !== 9'd511 || full9 !== 1'b0) begin
               errors++;
               $display("FAIL full_k256 got nc=%0d full=%b want 511 0", nc9, full9);
            end
         end
         if (k >= 257) begin
            checks++;
            if (nc9 !== 9'd511 || full9 !== 1'b1) begin
               errors++;
               $display("FAIL full_k%0d got nc=%0d full=%b want 511 1", k, nc9, full9);
            end
         end
         @(negedge clk);
      end
      checks++; if (err9 !== 1'b0) begin errors++; $display("FAIL full_error got %b want 0", err9); end
   endtask

   initial begin
      rst              = 1'b1;
      bus12.code_in    = 12'd0;
      bus12.code_valid = 1'b0;
      bus12.char_ready = 1'b1;
      bus9.code_in     = 9'd0;
      bus9.code_valid  = 1'b0;
      bus9.char_ready  = 1'b1;
      test_reset();
      test_stream(1'b0);
      test_stream(1'b1);
      test_bad_first();
      test_bad_code();
      test_reset_mid_emit();
      test_dict_full();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
